// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional trap on unknown opcodes is enabled by defining MULTICYCLE_ILLEGAL_TRAP_EN.
module multicycle_control #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic [1:0]         pc_source,
  output logic [2:0]         alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ANDIEX  = 4'd10,
    S_ORIEX   = 4'd11,
    S_IMMWB   = 4'd12,
    S_JEX     = 4'd13,
    S_TRAP    = 4'd14,
    S_UNUSED  = 4'd15
  } state_e;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ANDI:      state_d = S_ANDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JEX;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX, S_ANDIEX, S_ORIEX: state_d = S_IMMWB;
      S_IMMWB:   state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP:    state_d = S_TRAP;
`else
      S_TRAP:    state_d = S_FETCH;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Outputs decode the state directly so FETCH can follow mem_ready in the same cycle;
  // reset gates the enables because the state already reads FETCH during reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    pc_source     = '0;
    alu_op        = '0;
    alu_src_a     = 1'b0;
    alu_src_b     = '0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    illegal_op    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 3'b010;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b100;
      end
      S_RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b011;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_ADDIEX, S_ANDIEX, S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (state_q == S_ADDIEX) ? 3'b010 :
                    (state_q == S_ANDIEX) ? 3'b000 : 3'b001;
      end
      S_IMMWB: reg_write = 1'b1;
      S_JEX: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: illegal_op = 1'b1;
`endif
      default: ;
    endcase
    if (!reset_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      mem_read      = 1'b0;
      illegal_op    = 1'b0;
    end
  end

  assign state_dbg = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a queue-based instruction timing model.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal_op;
  } out_t;

  typedef struct {
    int         st;
    logic       rdy;
    logic [5:0] op;
  } step_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic       alu_src_a, reg_write, reg_dst, illegal_op;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  step_t      exp_q[$];
  logic [3:0] obs_st[$];
  out_t       obs_out[$];

  multicycle_control #(.OP_W(6), .STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .pc_source(pc_source), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic out_t observed();
    return out_t'({pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b,
                   reg_write, reg_dst, illegal_op});
  endfunction

  // Control word for each named machine step, straight from the state table.
  function automatic out_t exp_out(int st, logic rdy);
    out_t o = '0;
    case (st)
      0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b010; o.ir_write = rdy; o.pc_write = rdy; end
      1:  begin o.alu_src_b = 2'b11; o.alu_op = 3'b010; end
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b010; end
      3:  begin o.mem_read = 1; o.i_or_d = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      5:  begin o.mem_write = 1; o.i_or_d = 1; end
      6:  begin o.alu_src_a = 1; o.alu_op = 3'b100; end
      7:  begin o.reg_write = 1; o.reg_dst = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = 3'b011; o.pc_write_cond = 1; o.pc_source = 2'b01; end
      9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b010; end
      10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b000; end
      11: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b001; end
      12: o.reg_write = 1;
      13: begin o.pc_write = 1; o.pc_source = 2'b10; end
      14: o.illegal_op = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic add_mem(int st, int waits, logic [5:0] op);
    for (int i = 0; i < waits; i++) exp_q.push_back('{st, 1'b0, op});
    exp_q.push_back('{st, 1'b1, op});
  endtask

  task automatic add_plain(int st, logic [5:0] op);
    exp_q.push_back('{st, 1'($urandom % 2), op});
  endtask

  // Expected step sequence of one instruction, from the per-opcode path and wait counts.
  task automatic build_instr(logic [5:0] op, int fw, int mw);
    add_mem(0, fw, op);
    add_plain(1, op);
    case (op)
      6'b000000: begin add_plain(6, op); add_plain(7, op); end
      6'b100011: begin add_plain(2, op); add_mem(3, mw, op); add_plain(4, op); end
      6'b101011: begin add_plain(2, op); add_mem(5, mw, op); end
      6'b000100: add_plain(8, op);
      6'b001000: begin add_plain(9, op); add_plain(12, op); end
      6'b001100: begin add_plain(10, op); add_plain(12, op); end
      6'b001101: begin add_plain(11, op); add_plain(12, op); end
      6'b000010: add_plain(13, op);
      default: ;
    endcase
  endtask

  task automatic play();
    obs_st.delete();
    obs_out.delete();
    foreach (exp_q[i]) begin
      @(negedge clk);
      opcode    = exp_q[i].op;
      mem_ready = exp_q[i].rdy;
      #1;
      obs_st.push_back(state_dbg);
      obs_out.push_back(observed());
    end
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (state_dbg !== 4'd0 || {pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read, illegal_op} !== 7'b0) begin
      errors++;
      $display("FAIL reset_async: state=%0d enables=%b, expected state=0 enables=0000000", state_dbg,
               {pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read, illegal_op});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state_dbg !== 4'd0 || {pc_write, ir_write, mem_read} !== 3'b0) begin
      errors++;
      $display("FAIL reset_hold: state=%0d pc_write/ir_write/mem_read=%b, expected 0/000", state_dbg,
               {pc_write, ir_write, mem_read});
    end
    mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_rtype();
    build_instr(6'b000000, 0, 0);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_st[i] !== 4'(exp_q[i].st) || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].rdy)) begin
        errors++;
        $display("FAIL rtype step%0d: state=%0d out=%b, expected state=%0d out=%b", i, obs_st[i], obs_out[i],
                 exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].rdy));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_lw_wait();
    build_instr(6'b100011, 0, 2);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_st[i] !== 4'(exp_q[i].st) || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].rdy)) begin
        errors++;
        $display("FAIL lw_wait step%0d: state=%0d out=%b, expected state=%0d out=%b", i, obs_st[i], obs_out[i],
                 exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].rdy));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_sw_beq_j();
    build_instr(6'b101011, 0, 0);
    build_instr(6'b000100, 0, 0);
    build_instr(6'b000010, 0, 0);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_st[i] !== 4'(exp_q[i].st) || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].rdy)) begin
        errors++;
        $display("FAIL sw_beq_j step%0d: state=%0d out=%b, expected state=%0d out=%b", i, obs_st[i], obs_out[i],
                 exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].rdy));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_imm();
    build_instr(6'b001000, 0, 0);
    build_instr(6'b001100, 0, 0);
    build_instr(6'b001101, 0, 0);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_st[i] !== 4'(exp_q[i].st) || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].rdy)) begin
        errors++;
        $display("FAIL imm step%0d: state=%0d out=%b, expected state=%0d out=%b", i, obs_st[i], obs_out[i],
                 exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].rdy));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_fetch_stall();
    build_instr(6'b000000, 3, 0);
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_st[i] !== 4'(exp_q[i].st) || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].rdy)) begin
        errors++;
        $display("FAIL fetch_stall step%0d: state=%0d out=%b, expected state=%0d out=%b", i, obs_st[i], obs_out[i],
                 exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].rdy));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_illegal();
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    build_instr(6'b111111, 0, 0);
    for (int i = 0; i < 10; i++) add_plain(14, 6'b111111);
`else
    build_instr(6'b111111, 0, 0);
    build_instr(6'b000000, 0, 0);
`endif
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_st[i] !== 4'(exp_q[i].st) || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].rdy)) begin
        errors++;
        $display("FAIL illegal step%0d: state=%0d out=%b, expected state=%0d out=%b", i, obs_st[i], obs_out[i],
                 exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].rdy));
      end
    end
    exp_q.delete();
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (state_dbg !== 4'd0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL trap_clear: state=%0d illegal_op=%b, expected state=0 illegal_op=0", state_dbg, illegal_op);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
`endif
  endtask

  task automatic test_reset_mid_memwr();
    build_instr(6'b101011, 0, 5);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_st[i] !== 4'(exp_q[i].st) || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].rdy)) begin
        errors++;
        $display("FAIL memwr_pre step%0d: state=%0d out=%b, expected state=%0d out=%b", i, obs_st[i], obs_out[i],
                 exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].rdy));
      end
    end
    exp_q.delete();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (state_dbg !== 4'd0 || {mem_write, mem_read, reg_write} !== 3'b000) begin
      errors++;
      $display("FAIL memwr_reset: state=%0d mem_write/mem_read/reg_write=%b, expected state=0 000", state_dbg,
               {mem_write, mem_read, reg_write});
    end
    mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] legal [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b001000, 6'b001100, 6'b001101, 6'b000010};
    logic [5:0] op;
    for (int n = 0; n < 150; n++) begin
      op = legal[$urandom_range(0, 7)];
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
`endif
      build_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    play();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_st[i] !== 4'(exp_q[i].st) || obs_out[i] !== exp_out(exp_q[i].st, exp_q[i].rdy)) begin
        errors++;
        $display("FAIL random step%0d op=%b: state=%0d out=%b, expected state=%0d out=%b", i, exp_q[i].op,
                 obs_st[i], obs_out[i], exp_q[i].st, exp_out(exp_q[i].st, exp_q[i].rdy));
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_beq_j();
    test_imm();
    test_fetch_stall();
    test_illegal();
    test_reset_mid_memwr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
